// File: rtl/processor_pkg.sv
// Shared definitions for the multicycle MIPS-subset core: FSM states, opcode/funct
// encodings, ALU operations and the decoded control word.
package processor_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_EXECUTE,
        S_MEMORY,
        S_WRITEBACK
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL     = 6'h00;
    localparam logic [5:0] FN_SRL     = 6'h02;
    localparam logic [5:0] FN_SRA     = 6'h03;
    localparam logic [5:0] FN_SYSCALL = 6'h0C;
    localparam logic [5:0] FN_ADD     = 6'h20;
    localparam logic [5:0] FN_ADDU    = 6'h21;
    localparam logic [5:0] FN_SUB     = 6'h22;
    localparam logic [5:0] FN_SUBU    = 6'h23;
    localparam logic [5:0] FN_AND     = 6'h24;
    localparam logic [5:0] FN_OR      = 6'h25;
    localparam logic [5:0] FN_XOR     = 6'h26;
    localparam logic [5:0] FN_NOR     = 6'h27;
    localparam logic [5:0] FN_SLT     = 6'h2A;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
        ALU_SLT, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
    } alu_op_t;

    typedef struct packed {
        logic    supported;
        alu_op_t alu_op;
        logic    use_imm;
        logic    zext_imm;
        logic    dest_rt;
        logic    reg_write;
        logic    mem_read;
        logic    mem_write;
        logic    syscall;
    } ctrl_t;

    function automatic ctrl_t decode(input logic [5:0] opcode, input logic [5:0] funct);
        ctrl_t c;
        c = '0;
        c.alu_op = ALU_ADD;
        // I-type defaults; R-type and stores override below
        c.supported = 1'b1;
        c.use_imm   = 1'b1;
        c.dest_rt   = 1'b1;
        c.reg_write = 1'b1;
        case (opcode)
            OP_RTYPE: begin
                c.use_imm = 1'b0;
                c.dest_rt = 1'b0;
                case (funct)
                    FN_ADD, FN_ADDU: c.alu_op = ALU_ADD;
                    FN_SUB, FN_SUBU: c.alu_op = ALU_SUB;
                    FN_AND:          c.alu_op = ALU_AND;
                    FN_OR:           c.alu_op = ALU_OR;
                    FN_XOR:          c.alu_op = ALU_XOR;
                    FN_NOR:          c.alu_op = ALU_NOR;
                    FN_SLT:          c.alu_op = ALU_SLT;
                    FN_SLL:          c.alu_op = ALU_SLL;
                    FN_SRL:          c.alu_op = ALU_SRL;
                    FN_SRA:          c.alu_op = ALU_SRA;
                    FN_SYSCALL: begin
                        c.reg_write = 1'b0;
                        c.syscall   = 1'b1;
                    end
                    default: begin
                        c.supported = 1'b0;
                        c.reg_write = 1'b0;
                    end
                endcase
            end
            OP_ADDI, OP_ADDIU: c.alu_op = ALU_ADD;
            OP_SLTI:           c.alu_op = ALU_SLT;
            OP_ANDI: begin c.alu_op = ALU_AND; c.zext_imm = 1'b1; end
            OP_ORI:  begin c.alu_op = ALU_OR;  c.zext_imm = 1'b1; end
            OP_XORI: begin c.alu_op = ALU_XOR; c.zext_imm = 1'b1; end
            OP_LUI:            c.alu_op = ALU_LUI;
            OP_LW:             c.mem_read = 1'b1;
            OP_SW: begin
                c.reg_write = 1'b0;
                c.mem_write = 1'b1;
            end
            default: begin
                c.supported = 1'b0;
                c.reg_write = 1'b0;
            end
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multicycle_processor_if.sv
// Instruction handshake and status bus between a host (master) and the core control (slave).
interface multicycle_processor_if;
    logic        instrValid;
    logic [31:0] instruction;
    logic        instrReady;
    logic        busy;
    logic        syscallValid;

    modport master (output instrValid, instruction, input instrReady, busy, syscallValid);
    modport slave  (input instrValid, instruction, output instrReady, busy, syscallValid);
endinterface

// File: rtl/multicycle_control.sv
// Instruction register, decode and the five-state sequencing FSM of the core.
module multicycle_control
    import processor_pkg::*;
(
    input  logic                          clk,
    input  logic                          reset,
    multicycle_processor_if.slave         bus,
    output state_t                        state_o,
    output ctrl_t                         ctrl_o,
    output logic [31:0]                   ir_o,
    output logic                          retire_o
);

    state_t      state_q, state_d;
    logic [31:0] ir_q;
    ctrl_t       ctrl;
    logic        ready;
    logic        sys_v;
    logic        retire;

    assign ctrl     = decode(ir_q[31:26], ir_q[5:0]);
    assign ready    = (state_q == S_IDLE) && !reset;
    assign state_o  = state_q;
    assign ctrl_o   = ctrl;
    assign ir_o     = ir_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            if (bus.instrValid && ready) ir_q <= bus.instruction;
        end
    end

    always_comb begin
        state_d = state_q;
        sys_v   = 1'b0;
        retire  = 1'b0;
        case (state_q)
            S_IDLE:      if (bus.instrValid && ready) state_d = S_DECODE;
            S_DECODE:    state_d = ctrl.supported ? S_EXECUTE : S_IDLE;
            S_EXECUTE: begin
                if (ctrl.syscall) begin
                    state_d = S_IDLE;
                    sys_v   = 1'b1;
                    retire  = 1'b1;
                end else if (ctrl.mem_read || ctrl.mem_write) begin
                    state_d = S_MEMORY;
                end else begin
                    state_d = S_WRITEBACK;
                end
            end
            S_MEMORY: begin
                if (ctrl.mem_read) begin
                    state_d = S_WRITEBACK;
                end else begin
                    state_d = S_IDLE;
                    retire  = 1'b1;
                end
            end
            S_WRITEBACK: begin
                state_d = S_IDLE;
                retire  = 1'b1;
            end
            default:     state_d = S_IDLE;
        endcase
    end

    // Status outputs are forced quiet while reset is held, whatever the state
    assign bus.instrReady   = ready;
    assign bus.busy         = (state_q != S_IDLE) && !reset;
    assign bus.syscallValid = sys_v && !reset;
    assign retire_o         = retire && !reset;

endmodule

// File: rtl/multicycle_processor.sv
// Multicycle MIPS-subset core: register file, data memory and ALU datapath around
// the sequencing control unit.
module multicycle_processor
    import processor_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int REG_COUNT = 32,
    parameter int MEM_WORDS = 256
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             instrValid,
    input  logic [31:0]      instruction,
    output logic             instrReady,
    output logic             busy,
    output logic             syscallValid,
    output logic [WIDTH-1:0] syscallOut,
    output logic [WIDTH-1:0] retiredCount
);

    localparam int RW = $clog2(REG_COUNT);
    localparam int AW = $clog2(MEM_WORDS);
    localparam logic [RW-1:0] REG_A0 = RW'(4);

    multicycle_processor_if bus ();

    state_t      state;
    ctrl_t       ctrl;
    logic [31:0] ir;
    logic        retire;

    assign bus.instrValid  = instrValid;
    assign bus.instruction = instruction;
    assign instrReady      = bus.instrReady;
    assign busy            = bus.busy;
    assign syscallValid    = bus.syscallValid;

    multicycle_control u_ctrl (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .state_o  (state),
        .ctrl_o   (ctrl),
        .ir_o     (ir),
        .retire_o (retire)
    );

    logic [WIDTH-1:0] regs_q [REG_COUNT];
    logic [WIDTH-1:0] mem_q  [MEM_WORDS];
    logic [WIDTH-1:0] a_q, b_q, alu_q, mdr_q, syscall_q, retired_q;

    logic [RW-1:0]    rs, rt, rd, dest;
    logic [4:0]       shamt;
    logic [15:0]      imm;
    logic [WIDTH-1:0] imm_ext, op_b, alu_res;
    logic [AW-1:0]    mem_idx;
    logic             reg_we;

    assign rs      = ir[21 +: RW];
    assign rt      = ir[16 +: RW];
    assign rd      = ir[11 +: RW];
    assign shamt   = ir[10:6];
    assign imm     = ir[15:0];
    assign dest    = ctrl.dest_rt ? rt : rd;
    assign imm_ext = ctrl.zext_imm ? {{(WIDTH-16){1'b0}}, imm} : {{(WIDTH-16){imm[15]}}, imm};
    assign op_b    = ctrl.use_imm ? imm_ext : b_q;
    // Word addressing: byte offset dropped, upper bits wrap around the memory
    assign mem_idx = alu_q[AW+1:2];
    assign reg_we  = ctrl.supported && ctrl.reg_write && (dest != '0);

    always_comb begin
        alu_res = '0;
        case (ctrl.alu_op)
            ALU_ADD: alu_res = a_q + op_b;
            ALU_SUB: alu_res = a_q - op_b;
            ALU_AND: alu_res = a_q & op_b;
            ALU_OR:  alu_res = a_q | op_b;
            ALU_XOR: alu_res = a_q ^ op_b;
            ALU_NOR: alu_res = ~(a_q | op_b);
            ALU_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(op_b))};
            ALU_SLL: alu_res = b_q << shamt;
            ALU_SRL: alu_res = b_q >> shamt;
            ALU_SRA: alu_res = $unsigned($signed(b_q) >>> shamt);
            ALU_LUI: alu_res = WIDTH'({imm, 16'h0000});
            default: alu_res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= '0;
            for (int i = 0; i < MEM_WORDS; i++) mem_q[i] <= '0;
            a_q       <= '0;
            b_q       <= '0;
            alu_q     <= '0;
            mdr_q     <= '0;
            syscall_q <= '0;
            retired_q <= '0;
        end else begin
            case (state)
                S_DECODE: begin
                    a_q <= regs_q[rs];
                    b_q <= regs_q[rt];
                end
                S_EXECUTE: begin
                    alu_q <= alu_res;
                    if (ctrl.syscall) syscall_q <= regs_q[REG_A0];
                end
                S_MEMORY: begin
                    if (ctrl.mem_read)  mdr_q <= mem_q[mem_idx];
                    if (ctrl.mem_write) mem_q[mem_idx] <= b_q;
                end
                S_WRITEBACK: begin
                    if (reg_we) regs_q[dest] <= ctrl.mem_read ? mdr_q : alu_q;
                end
                default: ;
            endcase
            if (retire) retired_q <= retired_q + WIDTH'(1);
        end
    end

    assign syscallOut   = syscall_q;
    assign retiredCount = retired_q;

endmodule
